prll_bs_drvr_ndpnt: RTL

PRLL_BS_DRVR_NDPNT -- requirements
Module: prll_bs_drvr_ndpnt

---
 rtl/prll_bs_pkg.sv | 12 +
 rtl/prll_bs_fifo.sv | 57 +++++
 rtl/prll_bs_drvr_ndpnt.sv | 90 +++++++++
 3 files changed

// File: rtl/prll_bs_pkg.sv
// Shared constants and the pointer-width helper for the parallel bus driver endpoint.
package prll_bs_pkg;

  localparam int DEF_BITS  = 32;
  localparam int DEF_DEPTH = 8;

  // Pointer width for a power-of-two depth; the count needs one extra bit to hold "full".
  function automatic int ptr_w(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/prll_bs_fifo.sv
// First-word-fall-through circular FIFO with full/empty status and a same-cycle overflow pulse.
module prll_bs_fifo
  import prll_bs_pkg::*;
#(
  parameter int bits  = DEF_BITS,
  parameter int depth = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [bits-1:0] wr_data,
  input  logic            rd,
  output logic [bits-1:0] rd_data,
  output logic            empty,
  output logic            full,
  output logic            ovf
);

  localparam int PW = ptr_w(depth);
  localparam int CW = PW + 1;

  logic [bits-1:0] mem [depth];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            wr_acc;
  logic            rd_acc;

  assign empty   = (count == '0);
  assign full    = (count == CW'(depth));
  assign wr_acc  = wr && !full;
  assign rd_acc  = rd && !empty;
  assign ovf     = wr && full;
  assign rd_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !reset) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/prll_bs_drvr_ndpnt.sv
// Parallel bus driver endpoint: TX FIFO toward the bus, RX FIFO from the bus, sticky drop flags.
// Optional drop counter output enabled by defining PRLL_BS_DRVR_STATS_EN.
module prll_bs_drvr_ndpnt
  import prll_bs_pkg::*;
#(
  parameter int bits  = DEF_BITS,
  parameter int depth = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [bits-1:0] wr_data,
  output logic            tx_full,
  output logic            pndng,
  output logic [bits-1:0] D_pop,
  input  logic            pop,
  input  logic            push,
  input  logic [bits-1:0] D_push,
  input  logic            rd_en,
  output logic [bits-1:0] rd_data,
  output logic            rx_pndng,
  output logic            tx_ovf,
  output logic            rx_ovf,
  input  logic            clr_err
`ifdef PRLL_BS_DRVR_STATS_EN
  ,
  output logic [15:0]     drop_cnt
`endif
);

  logic tx_empty;
  logic tx_drop;
  logic rx_empty;
  logic rx_full_unused;
  logic rx_drop;

  prll_bs_fifo #(.bits(bits), .depth(depth)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .wr      (wr_en),
    .wr_data (wr_data),
    .rd      (pop),
    .rd_data (D_pop),
    .empty   (tx_empty),
    .full    (tx_full),
    .ovf     (tx_drop)
  );

  prll_bs_fifo #(.bits(bits), .depth(depth)) u_rx (
    .clk     (clk),
    .reset   (reset),
    .wr      (push),
    .wr_data (D_push),
    .rd      (rd_en),
    .rd_data (rd_data),
    .empty   (rx_empty),
    .full    (rx_full_unused),
    .ovf     (rx_drop)
  );

  assign pndng    = !tx_empty;
  assign rx_pndng = !rx_empty;

  // A fresh drop outranks clr_err so an overflow in the clearing cycle is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (tx_drop)      tx_ovf <= 1'b1;
      else if (clr_err) tx_ovf <= 1'b0;
      if (rx_drop)      rx_ovf <= 1'b1;
      else if (clr_err) rx_ovf <= 1'b0;
    end
  end

`ifdef PRLL_BS_DRVR_STATS_EN
  logic [16:0] cnt_sum;

  always_comb begin
    cnt_sum = (clr_err ? 17'd0 : {1'b0, drop_cnt}) + 17'(tx_drop) + 17'(rx_drop);
  end

  always_ff @(posedge clk) begin
    if (reset) drop_cnt <= '0;
    else       drop_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule
